// File: rtl/cxl_arb_pkg.sv
// Shared types and constants for the CXL request arbiter.
package cxl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_PREFETCH = 0;
  localparam int unsigned REQ_DMA      = 1;
  localparam int unsigned REQ_WB       = 2;

  localparam int unsigned DEF_NUM_REQ      = 3;
  localparam int unsigned DEF_STARVE_WIDTH = 4;

endpackage

// File: rtl/cxl_rr_pick.sv
// Combinational one-hot winner picker: starved first, then fixed priority for
// requester 0, then round-robin after the last grant.
module cxl_rr_pick
  import cxl_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [NUM_REQ-1:0] i_starved,
  input  logic               i_prio_en,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_grant
);

  logic w_found;

  always_comb begin
    int unsigned idx;
    o_grant = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_valid[i] && i_starved[i]) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    if (!w_found && i_prio_en && i_valid[0]) begin
      o_grant[0] = 1'b1;
      w_found    = 1'b1;
    end
    // Scan from last_grant+1, wrapping, ending on last_grant itself.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(i_last_grant) + k) % NUM_REQ;
      if (!w_found && i_valid[idx]) begin
        o_grant[idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cxl_req_arbiter.sv
// Arbitrates several requesters onto one CXL memory request/response port,
// one transaction outstanding at a time.
module cxl_req_arbiter
  import cxl_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned STARVE_WIDTH = DEF_STARVE_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              rq_valid,
  output logic [NUM_REQ-1:0]              rq_ready,
  input  logic [NUM_REQ-1:0]              rq_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   rq_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   rq_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] rq_strb,
  input  logic [NUM_REQ*8-1:0]            rq_len,
  output logic [NUM_REQ-1:0]              rs_valid,
  input  logic [NUM_REQ-1:0]              rs_ready,
  output logic [DATA_WIDTH-1:0]           rs_data,
  output logic                            rs_last,
  output logic                            m_req_valid,
  input  logic                            m_req_ready,
  output logic                            m_req_write,
  output logic [ADDR_WIDTH-1:0]           m_req_addr,
  output logic [DATA_WIDTH-1:0]           m_req_data,
  output logic [DATA_WIDTH/8-1:0]         m_req_strb,
  output logic [7:0]                      m_req_len,
  input  logic                            m_resp_valid,
  input  logic [DATA_WIDTH-1:0]           m_resp_data,
  input  logic                            m_resp_last,
  output logic                            m_resp_ready,
  input  logic                            prio_en,
  input  logic [STARVE_WIDTH-1:0]         starve_limit,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  arb_state_e                            r_state;
  logic [ID_W-1:0]                       r_owner;
  logic [ID_W-1:0]                       r_last_grant;
  logic [NUM_REQ-1:0][STARVE_WIDTH-1:0]  r_starve;
  logic                                  r_m_req_valid;
  logic                                  r_m_req_write;
  logic [ADDR_WIDTH-1:0]                 r_m_req_addr;
  logic [DATA_WIDTH-1:0]                 r_m_req_data;
  logic [STRB_W-1:0]                     r_m_req_strb;
  logic [7:0]                            r_m_req_len;

  logic [NUM_REQ-1:0]    w_starved;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_do_grant;
  logic [ID_W-1:0]       w_win_idx;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [STRB_W-1:0]     w_sel_strb;
  logic [7:0]            w_sel_len;
  logic                  w_resp_ready;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_starved[i] = (starve_limit != '0) && (r_starve[i] >= starve_limit);
    end
  end

  cxl_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_valid      (rq_valid),
    .i_starved    (w_starved),
    .i_prio_en    (prio_en),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_do_grant = (r_state == IDLE) && (|rq_valid);

  always_comb begin
    w_win_idx   = '0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    w_sel_strb  = '0;
    w_sel_len   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_idx   = ID_W'(i);
        w_sel_write = rq_write[i];
        w_sel_addr  = rq_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data  = rq_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_strb  = rq_strb[i*STRB_W +: STRB_W];
        w_sel_len   = rq_len[i*8 +: 8];
      end
    end
  end

  // rst_n gating keeps rq_ready low while reset is held, even in IDLE.
  assign rq_ready = (w_do_grant && rst_n) ? w_grant : '0;

  always_comb begin
    rs_valid     = '0;
    w_resp_ready = 1'b0;
    rs_data      = '0;
    rs_last      = 1'b0;
    if (r_state == WAIT_RESP) begin
      rs_valid[r_owner] = m_resp_valid;
      w_resp_ready      = rs_ready[r_owner];
      rs_data           = m_resp_data;
      rs_last           = m_resp_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_owner       <= '0;
      r_last_grant  <= ID_W'(NUM_REQ - 1);
      r_starve      <= '0;
      r_m_req_valid <= 1'b0;
      r_m_req_write <= 1'b0;
      r_m_req_addr  <= '0;
      r_m_req_data  <= '0;
      r_m_req_strb  <= '0;
      r_m_req_len   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_do_grant) begin
            r_state       <= ISSUE;
            r_owner       <= w_win_idx;
            r_last_grant  <= w_win_idx;
            r_m_req_valid <= 1'b1;
            r_m_req_write <= w_sel_write;
            r_m_req_addr  <= w_sel_addr;
            r_m_req_data  <= w_sel_data;
            r_m_req_strb  <= w_sel_strb;
            r_m_req_len   <= w_sel_len;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
              if (w_grant[i]) begin
                r_starve[i] <= '0;
              end else if (rq_valid[i] && (r_starve[i] != {STARVE_WIDTH{1'b1}})) begin
                r_starve[i] <= r_starve[i] + STARVE_WIDTH'(1);
              end
            end
          end
        end
        ISSUE: begin
          if (m_req_ready) begin
            r_m_req_valid <= 1'b0;
            r_state       <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (m_resp_valid && w_resp_ready && m_resp_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_req_valid  = r_m_req_valid;
  assign m_req_write  = r_m_req_write;
  assign m_req_addr   = r_m_req_addr;
  assign m_req_data   = r_m_req_data;
  assign m_req_strb   = r_m_req_strb;
  assign m_req_len    = r_m_req_len;
  assign m_resp_ready = w_resp_ready;
  assign busy         = (r_state != IDLE);
  assign grant_id     = r_owner;

endmodule
